integral_image_stream: RTL and testbench

- Streaming integral-image generator. Sits directly downstream of the pyramid downscaler in the Viola-Jones datapath.
- Consumes one downscaled pyramid level as a row-major pixel stream. Emits the summed-area table in the same order: ii[r][c] = sum of pix[r'][c'] for r'<=r, c'<=c.
- The Haar feature evaluator reads this table. Each pyramid level gets its own instance, sized by its WIDTH/HEIGHT.

---
 rtl/integral_image_stream.sv | 98 +++++++++
 tb/tb_integral_image_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/integral_image_stream.sv
// integral_image_stream: streaming summed-area table generator for one pyramid level.
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   in_valid/in_ready/in_pix      row-major pixel stream input
//   in_sof                        marks the accepted pixel as (0,0) of a new frame
//   out_valid/out_ready/out_ii    integral value output stream with backpressure
//   out_row, out_col              position of the value on out_ii
//   out_sof, out_eof              first / last element of the frame
//   frame_done                    pulses the cycle after the eof element handshakes out
module integral_image_stream #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int PIX_W  = 32,
    parameter int OUT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W-1:0]          in_pix,
    input  logic                      in_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_ii,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      frame_done
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    logic [RW-1:0]    row_q, row_d, cur_row, out_row_q, out_row_d;
    logic [CW-1:0]    col_q, col_d, cur_col, out_col_q, out_col_d;
    logic [OUT_W-1:0] row_acc_q, row_acc_d, row_sum, ii_sum, out_ii_q, out_ii_d;
    logic [OUT_W-1:0] lb_q [WIDTH];
    logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic             frame_done_q, frame_done_d, accept, last_col;
    always_comb begin
        in_ready     = !out_valid_q || out_ready;
        accept       = in_valid && in_ready;
        // an accepted sof pixel is (0,0) regardless of where the counters stand
        cur_row      = in_sof ? '0 : row_q;
        cur_col      = in_sof ? '0 : col_q;
        last_col     = cur_col == COL_LAST;
        row_sum      = (cur_col == '0 ? '0 : row_acc_q) + OUT_W'(in_pix);
        // row 0 has no previous row, so the stale line buffer is never used there
        ii_sum       = row_sum + (cur_row == '0 ? '0 : lb_q[cur_col]);
        col_d        = accept ? (last_col ? '0 : cur_col + CW'(1)) : col_q;
        row_d        = accept ? (last_col ? (cur_row == ROW_LAST ? '0 : cur_row + RW'(1)) : cur_row) : row_q;
        row_acc_d    = accept ? row_sum : row_acc_q;
        out_valid_d  = accept || (out_valid_q && !out_ready);
        out_ii_d     = accept ? ii_sum : out_ii_q;
        out_row_d    = accept ? cur_row : out_row_q;
        out_col_d    = accept ? cur_col : out_col_q;
        out_sof_d    = accept ? (cur_row == '0 && cur_col == '0) : out_sof_q;
        out_eof_d    = accept ? (cur_row == ROW_LAST && last_col) : out_eof_q;
        frame_done_d = out_valid_q && out_ready && out_eof_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            row_acc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ii_q     <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            row_acc_q    <= row_acc_d;
            out_valid_q  <= out_valid_d;
            out_ii_q     <= out_ii_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end
    // read-before-write of the same column: the read feeds ii_sum this cycle
    always_ff @(posedge clk) begin
        if (accept) lb_q[cur_col] <= ii_sum;
    end
    assign out_valid  = out_valid_q;
    assign out_ii     = out_ii_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_integral_image_stream.sv
// tb_integral_image_stream: randomized and directed checks of integral_image_stream against a summed-area model.
module tb_integral_image_stream;
    localparam int W = 160;
    localparam int H = 120;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic out_ready = 1'b1;
    logic [31:0] in_pix = '0;
    logic in_ready, out_valid, out_sof, out_eof, frame_done;
    logic [31:0] out_ii;
    logic [$clog2(H)-1:0] out_row;
    logic [$clog2(W)-1:0] out_col;

    integral_image_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(32), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_ii(out_ii),
        .out_row(out_row), .out_col(out_col), .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ii;
        int          row;
        int          col;
        logic        sof;
        logic        eof;
        int          ph;
    } beat_t;

    beat_t       q[$];
    logic [31:0] sat [H][W];
    int          mr = 0, mc = 0, phase = 0, fd_ph = 0, stalls = 0;
    int          beats[8], fds[8];
    int          n_vec = 0, n_err = 0;
    logic        fd_exp = 1'b0, rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // hand-computed values that pin the model for each directed frame
    task automatic literals(input beat_t b);
        case (b.ph)
            1: begin
                chk("ones_ii", out_ii, (b.row + 1) * (b.col + 1));
                if (b.eof) chk("ones_last", out_ii, 19200);
            end
            4: if (beats[4] == 0) begin
                chk("restart_row", 32'(out_row), 0);
                chk("restart_col", 32'(out_col), 0);
                chk("restart_sof", 32'(out_sof), 1);
                chk("restart_ii", out_ii, 5);
            end
            5: begin
                if (b.row == 0 && b.col == 0) chk("ovf_00", out_ii, 32'hFFFF_FFFF);
                if (b.row == 0 && b.col == 1) chk("ovf_01", out_ii, 32'hFFFF_FFFE);
                if (b.row == 1 && b.col == 1) chk("ovf_11", out_ii, 32'hFFFF_FFFC);
            end
            6: begin
                if (b.row == 0 && b.col == 0) chk("two_00", out_ii, 2);
                if (b.row == H - 1 && b.col == W - 1) chk("two_last", out_ii, 38400);
            end
            7: begin
                if (b.row == 59 && b.col == 79) chk("quad_59_79", out_ii, 0);
                if (b.row == 59 && b.col == 159) chk("quad_59_159", out_ii, 4800);
                if (b.row == 119 && b.col == 79) chk("quad_119_79", out_ii, 9600);
                if (b.row == 119 && b.col == 159) chk("quad_119_159", out_ii, 28800);
            end
            default: ;
        endcase
    endtask

    // compare process: mid-cycle, when inputs and registered outputs are stable
    always @(negedge clk) begin
        beat_t b;
        logic [31:0] v;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_ii", out_ii, 0);
            chk("rst_out_row", 32'(out_row), 0);
            chk("rst_out_col", 32'(out_col), 0);
            chk("rst_out_sof", 32'(out_sof), 0);
            chk("rst_out_eof", 32'(out_eof), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
            q.delete();
            mr = 0;
            mc = 0;
            fd_exp = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            if (frame_done) fds[fd_ph]++;
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            fd_exp = 1'b0;
            if (out_valid && q.size() != 0) begin
                b = q[0];
                chk("out_ii", out_ii, b.ii);
                chk("out_row", 32'(out_row), b.row);
                chk("out_col", 32'(out_col), b.col);
                chk("out_sof", 32'(out_sof), 32'(b.sof));
                chk("out_eof", 32'(out_eof), 32'(b.eof));
                if (out_ready) begin
                    literals(b);
                    beats[b.ph]++;
                    fd_exp = b.eof;
                    if (b.eof) fd_ph = b.ph;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    mr = 0;
                    mc = 0;
                end
                v = in_pix;
                if (mr > 0) v = v + sat[mr-1][mc];
                if (mc > 0) v = v + sat[mr][mc-1];
                if (mr > 0 && mc > 0) v = v - sat[mr-1][mc-1];
                sat[mr][mc] = v;
                q.push_back('{v, mr, mc, mr == 0 && mc == 0, mr == H - 1 && mc == W - 1, phase});
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] p, input logic s);
        logic acc;
        int   waited;
        waited = 0;
        in_valid = 1'b1;
        in_pix = p;
        in_sof = s;
        forever begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
            waited++;
            if (waited > 1000) begin
                n_err++;
                $display("FAIL in_ready_timeout: got 0, expected 1 within 1000 cycles");
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $fatal(1, "stuck");
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    function automatic logic [31:0] quad(input int r, input int c);
        return (r < 60) ? ((c < 80) ? 0 : 1) : ((c < 80) ? 2 : 3);
    endfunction

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (beats[i]) begin
            beats[i] = 0;
            fds[i] = 0;
        end
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        phase = 1;
        for (int i = 0; i < W * H; i++) send(1, i == 0);
        idle(3);
        chk("ones_beats", beats[1], W * H);
        chk("ones_frame_done", fds[1], 1);
        chk("ones_stalls", stalls, 0);
        phase = 2;
        rnd_ready = 1'b1;
        for (int i = 0; i < W * H; i++) send($urandom, i == 0);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("rand_beats", beats[2], W * H);
        chk("rand_frame_done", fds[2], 1);
        phase = 3;
        for (int i = 0; i < 500; i++) send(1, i == 0);
        phase = 4;
        send(5, 1'b1);
        for (int i = 0; i < 10; i++) send(1, 1'b0);
        phase = 5;
        for (int i = 0; i < 37 * W + 12; i++) send(32'hFFFF_FFFF, i == 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("restart_beats", beats[4], 11);
        chk("aborted_frame_done", fds[3] + fds[4] + fds[5], 0);
        stalls = 0;
        phase = 6;
        for (int i = 0; i < W * H; i++) send(2, 1'b0);
        phase = 7;
        for (int i = 0; i < W * H; i++) send(quad(i / W, i % W), 1'b0);
        idle(3);
        chk("two_beats", beats[6], W * H);
        chk("two_frame_done", fds[6], 1);
        chk("quad_beats", beats[7], W * H);
        chk("quad_frame_done", fds[7], 1);
        chk("b2b_stalls", stalls, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
